// File: rtl/clkdiv_gen_if.sv
// Configuration write channel for clkdiv_gen.
// The master drives the write fields; the slave returns cfg_ready.
interface clkdiv_gen_if #(
    parameter int DIV_W = 8
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;
    logic             cfg_en;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_phase, cfg_en,
        input  cfg_ready
    );
    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_phase, cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/clkdiv_gen.sv
// Multi-channel programmable clock divider with phase offsets,
// realignment on sync/config, and an extlock indicator.
module clkdiv_gen #(
    parameter int NCH         = 4,
    parameter int DIV_W       = 8,
    parameter int DEF_DIV     = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic           refclk,
    input  logic           reset_n,
    clkdiv_gen_if.slave    cfg,
    input  logic           sync,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] clk_en,
    output logic           extlock
);
    typedef enum logic [1:0] {
        S_RESET, S_ALIGN, S_SETTLE, S_LOCKED
    } state_t;

    localparam int              SC_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]      NCH_L   = 4'(NCH);
    localparam logic [DIV_W-1:0] ONE    = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO    = DIV_W'(2);
    localparam logic [DIV_W-1:0] DEF_D  = DIV_W'(DEF_DIV);

    state_t           state;
    logic [SC_W-1:0]  scnt;
    logic             acc;
    logic             hit;
    logic             realign;
    logic [DIV_W-1:0] eff_div;
    logic [DIV_W-1:0] eff_ph;

    logic [DIV_W-1:0] sh_div [NCH];
    logic [DIV_W-1:0] sh_ph  [NCH];
    logic [NCH-1:0]   sh_en;
    logic [DIV_W-1:0] div    [NCH];
    logic [NCH-1:0]   en;
    logic [DIV_W-1:0] cnt    [NCH];
    logic [DIV_W-1:0] aln    [NCH];
    logic [DIV_W-1:0] nxt    [NCH];
    logic [DIV_W-1:0] h_sh   [NCH];
    logic [DIV_W-1:0] h_run  [NCH];

    assign acc     = cfg.cfg_valid & cfg.cfg_ready;
    assign hit     = acc & ({1'b0, cfg.cfg_ch} < NCH_L);
    assign realign = sync | hit;
    assign eff_div = (cfg.cfg_div < TWO) ? TWO : cfg.cfg_div;
    assign eff_ph  = (cfg.cfg_phase < eff_div) ? cfg.cfg_phase : '0;

    // High time is ceil(D/2): odd divisors get the extra high cycle
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            aln[i]   = (sh_ph[i] == '0) ? '0 : sh_div[i] - sh_ph[i];
            h_sh[i]  = (sh_div[i] >> 1)
                     + {{(DIV_W-1){1'b0}}, sh_div[i][0]};
            nxt[i]   = (cnt[i] == div[i] - ONE) ? '0 : cnt[i] + ONE;
            h_run[i] = (div[i] >> 1)
                     + {{(DIV_W-1){1'b0}}, div[i][0]};
        end
    end

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_RESET;
            scnt          <= '0;
            extlock       <= 1'b0;
            cfg.cfg_ready <= 1'b0;
        end else begin
            unique case (state)
                S_RESET: begin
                    state <= S_ALIGN;
                end
                S_ALIGN: begin
                    state         <= S_SETTLE;
                    scnt          <= '0;
                    cfg.cfg_ready <= 1'b1;
                end
                S_SETTLE, S_LOCKED: begin
                    if (realign) begin
                        state         <= S_ALIGN;
                        scnt          <= '0;
                        extlock       <= 1'b0;
                        cfg.cfg_ready <= 1'b0;
                    end else if (state == S_SETTLE) begin
                        if (scnt == SC_LAST) begin
                            state   <= S_LOCKED;
                            extlock <= 1'b1;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Shadow regs load on accepted writes; live regs copy them at ALIGN
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                sh_div[i] <= DEF_D;
                sh_ph[i]  <= '0;
                div[i]    <= DEF_D;
                cnt[i]    <= '0;
            end
            sh_en   <= '1;
            en      <= '1;
            clk_out <= '0;
            clk_en  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (hit && (cfg.cfg_ch == 3'(i))) begin
                    sh_div[i] <= eff_div;
                    sh_ph[i]  <= eff_ph;
                    sh_en[i]  <= cfg.cfg_en;
                end
                if (state == S_ALIGN) begin
                    div[i]     <= sh_div[i];
                    en[i]      <= sh_en[i];
                    cnt[i]     <= sh_en[i] ? aln[i] : '0;
                    clk_out[i] <= sh_en[i] & (aln[i] < h_sh[i]);
                    clk_en[i]  <= sh_en[i] & (aln[i] == '0);
                end else if (state != S_RESET) begin
                    if (en[i]) begin
                        cnt[i]     <= nxt[i];
                        clk_out[i] <= nxt[i] < h_run[i];
                        clk_en[i]  <= nxt[i] == '0;
                    end else begin
                        cnt[i]     <= '0;
                        clk_out[i] <= 1'b0;
                        clk_en[i]  <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_clkdiv_gen.sv
// Bench for clkdiv_gen: time-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_clkdiv_gen;
    localparam int NCH = 4;
    localparam int DIV_W = 8;
    localparam int LOCK_CYCLES = 16;

    logic           refclk;
    logic           reset_n;
    logic           sync;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] clk_en;
    logic           extlock;

    int total = 0;
    int bad = 0;

    clkdiv_gen_if #(.DIV_W(DIV_W)) cif ();

    clkdiv_gen #(
        .NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(2), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .refclk(refclk),
        .reset_n(reset_n),
        .cfg(cif),
        .sync(sync),
        .clk_out(clk_out),
        .clk_en(clk_en),
        .extlock(extlock)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: output phase is (edges since last align) shifted by P mod D
    int t, base, align_at;
    bit m_ready, m_lock;
    int s_div [NCH];
    int s_ph  [NCH];
    bit s_en  [NCH];
    int l_div [NCH];
    int l_ph  [NCH];
    bit l_en  [NCH];
    logic [NCH-1:0] m_out, m_cen;

    task automatic model_reset();
        t = 0;
        base = -1;
        align_at = -1;
        m_ready = 0;
        m_lock = 0;
        for (int i = 0; i < NCH; i++) begin
            s_div[i] = 2; s_ph[i] = 0; s_en[i] = 1;
            l_div[i] = 2; l_ph[i] = 0; l_en[i] = 1;
        end
        m_out = '0;
        m_cen = '0;
    endtask

    task automatic model_step();
        bit hit;
        int d, p, k;
        t++;
        hit = cif.cfg_valid && m_ready && (int'(cif.cfg_ch) < NCH);
        if (t == 1) align_at = 2;
        if (hit) begin
            d = (int'(cif.cfg_div) < 2) ? 2 : int'(cif.cfg_div);
            p = (int'(cif.cfg_phase) < d) ? int'(cif.cfg_phase) : 0;
            s_div[cif.cfg_ch] = d;
            s_ph[cif.cfg_ch] = p;
            s_en[cif.cfg_ch] = cif.cfg_en;
        end
        if (t == align_at) begin
            base = t;
            m_ready = 1;
            for (int i = 0; i < NCH; i++) begin
                l_div[i] = s_div[i]; l_ph[i] = s_ph[i]; l_en[i] = s_en[i];
            end
        end else if (m_ready && (sync || hit)) begin
            align_at = t + 1;
            m_ready = 0;
        end
        m_lock = m_ready && (t >= align_at + LOCK_CYCLES);
        for (int i = 0; i < NCH; i++) begin
            if (base >= 0 && l_en[i]) begin
                k = (t - base + l_div[i] - l_ph[i]) % l_div[i];
                m_out[i] = k < (l_div[i] + 1) / 2;
                m_cen[i] = k == 0;
            end else begin
                m_out[i] = 1'b0;
                m_cen[i] = 1'b0;
            end
        end
    endtask

    initial model_reset();
    always @(negedge reset_n) model_reset();

    always @(posedge refclk) begin
        if (reset_n) begin
            model_step();
            #1;
            if (reset_n) begin
                chk("m_clk_out", 32'(clk_out), 32'(m_out));
                chk("m_clk_en", 32'(clk_en), 32'(m_cen));
                chk("m_extlock", 32'(extlock), 32'(m_lock));
                chk("m_cfg_ready", 32'(cif.cfg_ready), 32'(m_ready));
            end
        end
    end

    task automatic cfg_wr(input int ch, input int dv, input int ph,
                          input bit en);
        @(negedge refclk);
        cif.cfg_valid = 1'b1;
        cif.cfg_ch = 3'(ch);
        cif.cfg_div = DIV_W'(dv);
        cif.cfg_phase = DIV_W'(ph);
        cif.cfg_en = en;
        @(negedge refclk);
        cif.cfg_valid = 1'b0;
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (!extlock && n < 100) begin
            @(posedge refclk);
            #2;
            n++;
        end
        chk("lock_wait", 32'(extlock), 32'd1);
    endtask

    task automatic lock_seq(input string tag);
        @(negedge refclk);
        reset_n = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            @(posedge refclk);
            #2;
            if (e == 1) chk({tag, "_rdy_e1"}, 32'(cif.cfg_ready), 32'd0);
            if (e == 2) begin
                chk({tag, "_rdy_e2"}, 32'(cif.cfg_ready), 32'd1);
                chk({tag, "_out_e2"}, 32'(clk_out), 32'hF);
                chk({tag, "_cen_e2"}, 32'(clk_en), 32'hF);
            end
            if (e == 3) chk({tag, "_out_e3"}, 32'(clk_out), 32'd0);
            if (e == 17) chk({tag, "_lock_e17"}, 32'(extlock), 32'd0);
            if (e == 18) chk({tag, "_lock_e18"}, 32'(extlock), 32'd1);
        end
    endtask

    initial begin
        int n;
        int r3, r3b, r2, r2b, zeros;
        logic [9:0] pat_o, pat_e;
        logic p0, p2, p3, err_a, err_b, err_c;

        reset_n = 1'b0;
        sync = 1'b0;
        cif.cfg_valid = 1'b0;
        cif.cfg_ch = '0;
        cif.cfg_div = '0;
        cif.cfg_phase = '0;
        cif.cfg_en = 1'b0;
        repeat (3) @(posedge refclk);
        #2;
        chk("rst_out", 32'(clk_out), 32'd0);
        chk("rst_cen", 32'(clk_en), 32'd0);
        chk("rst_lock", 32'(extlock), 32'd0);
        chk("rst_rdy", 32'(cif.cfg_ready), 32'd0);

        lock_seq("boot");

        // ch1 div 5: 3 high / 2 low, strobe every 5th
        cfg_wr(1, 5, 0, 1);
        chk("div5_lockdrop", 32'(extlock), 32'd0);
        chk("div5_rdydrop", 32'(cif.cfg_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge refclk);
            #2;
            pat_o[i] = clk_out[1];
            pat_e[i] = clk_en[1];
        end
        chk("div5_pat_out", 32'(pat_o), 32'(10'b0011100111));
        chk("div5_pat_cen", 32'(pat_e), 32'(10'b0000100001));
        wait_lock(n);
        chk("div5_relock", 32'(10 + n), 32'd17);

        // ch2 lags ch3 by 3, both period 8
        cfg_wr(2, 8, 3, 1);
        cfg_wr(3, 8, 0, 1);
        wait_lock(n);
        r3 = -1; r3b = -1; r2 = -1; r2b = -1;
        p2 = clk_out[2];
        p3 = clk_out[3];
        for (int i = 0; i < 30; i++) begin
            @(posedge refclk);
            #2;
            if (clk_out[3] && !p3) begin
                if (r3 < 0) r3 = i;
                else if (r3b < 0) r3b = i;
            end
            if (clk_out[2] && !p2 && r3 >= 0) begin
                if (r2 < 0) r2 = i;
                else if (r2b < 0) r2b = i;
            end
            p2 = clk_out[2];
            p3 = clk_out[3];
        end
        chk("ph3_lag", 32'(r2 - r3), 32'd3);
        chk("ph3_per3", 32'(r3b - r3), 32'd8);
        chk("ph3_per2", 32'(r2b - r2), 32'd8);

        // div 0/1 clamp to 2, phase >= div clamps to 0
        cfg_wr(0, 1, 0, 1);
        cfg_wr(1, 0, 0, 1);
        cfg_wr(2, 8, 9, 1);
        wait_lock(n);
        err_a = 0; err_b = 0; err_c = 0;
        p0 = clk_out[0];
        for (int i = 0; i < 16; i++) begin
            @(posedge refclk);
            #2;
            if (clk_out[0] == p0) err_a = 1;
            if (clk_out[1] != clk_out[0]) err_b = 1;
            if (clk_out[2] != clk_out[3]) err_c = 1;
            p0 = clk_out[0];
        end
        chk("clamp_div1_toggle", 32'(err_a), 32'd0);
        chk("clamp_div0_eq", 32'(err_b), 32'd0);
        chk("clamp_ph9", 32'(err_c), 32'd0);

        // out-of-range channel: accepted, no realign
        cfg_wr(6, 5, 1, 1);
        chk("ch6_lock", 32'(extlock), 32'd1);
        chk("ch6_rdy", 32'(cif.cfg_ready), 32'd1);
        @(posedge refclk);
        #2;
        chk("ch6_lock2", 32'(extlock), 32'd1);

        // sync and write together: one ALIGN cycle
        @(negedge refclk);
        sync = 1'b1;
        cif.cfg_valid = 1'b1;
        cif.cfg_ch = 3'd3;
        cif.cfg_div = 8'd4;
        cif.cfg_phase = 8'd1;
        cif.cfg_en = 1'b1;
        @(negedge refclk);
        sync = 1'b0;
        cif.cfg_valid = 1'b0;
        zeros = cif.cfg_ready ? 0 : 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge refclk);
            #2;
            if (!cif.cfg_ready) zeros++;
        end
        chk("sync_wr_ready_low", 32'(zeros), 32'd1);

        // disabled channel stays low
        cfg_wr(0, 2, 0, 0);
        wait_lock(n);
        err_a = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge refclk);
            #2;
            if (clk_out[0] || clk_en[0]) err_a = 1;
        end
        chk("dis_ch0", 32'(err_a), 32'd0);

        // reset mid-SETTLE, async clear, then default relock
        @(negedge refclk);
        sync = 1'b1;
        @(negedge refclk);
        sync = 1'b0;
        repeat (5) @(posedge refclk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_out", 32'(clk_out), 32'd0);
        chk("arst_cen", 32'(clk_en), 32'd0);
        chk("arst_lock", 32'(extlock), 32'd0);
        chk("arst_rdy", 32'(cif.cfg_ready), 32'd0);
        repeat (2) @(negedge refclk);
        lock_seq("rerst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clkdiv_gen.md
Name: clkdiv_gen

Overview:
- Parametrised multi-channel digital clock generator. Successor to the fixed two-output PLL wrapper.
- Derives NCH divided clocks and matching clock-enable strobes from one reference clock.
- Each channel has a runtime-programmable divisor, phase offset and enable.
- Phase-aligns all channels and reports lock through extlock. Sits beside the PLL and feeds low-rate logic (UART, timers, BRAM demo sequencers).

Parameters:
- NCH, 4, number of output channels (1..8).
- DIV_W, 8, width of divisor and phase fields.
- DEF_DIV, 2, divisor loaded into every channel at reset (>=2).
- LOCK_CYCLES, 16, refclk cycles spent in SETTLE before extlock asserts (>=1).

Ports:
- refclk  in  1  sole clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  configuration accepted when valid&ready.
- cfg_ch  in  3  target channel index.
- cfg_div  in  DIV_W  divisor.
- cfg_phase  in  DIV_W  phase offset in refclk cycles.
- cfg_en  in  1  channel enable.
- sync  in  1  single-cycle realign request.
- clk_out  out  NCH  divided clocks, registered.
- clk_en  out  NCH  one-cycle strobe coinciding with each clk_out rising edge.
- extlock  out  1  all channels aligned and settled.

Behaviour:
- Reset (async, reset_n low): all outputs 0; every channel div=DEF_DIV, phase=0, en=1; counters 0; state RESET.
- FSM states: RESET, ALIGN, SETTLE, LOCKED.
  - RESET -> ALIGN on the first edge after reset_n is high.
  - ALIGN -> SETTLE after exactly 1 cycle.
  - SETTLE counts LOCK_CYCLES cycles, then -> LOCKED.
  - SETTLE/LOCKED -> ALIGN on sync=1 or an accepted config write.
- extlock = 1 only in LOCKED, registered. It drops on the edge entering ALIGN. From reset release, extlock rises on edge LOCK_CYCLES+2.
- cfg_ready = 1 in SETTLE and LOCKED; 0 in RESET and ALIGN.
- Config writes:
  - An accepted write updates the channel's shadow registers, which take effect at the next ALIGN.
  - cfg_ch >= NCH: write is accepted but ignored, with no realign.
  - sync and an accepted write in the same cycle produce a single realign.
- Effective divisor D = max(cfg_div, 2). Effective phase P = cfg_phase if cfg_phase < D, else 0.
- High time H = (D+1)>>1. Odd D gives one extra high cycle (D=5: 3 high, 2 low).
- On the ALIGN edge, each channel loads cnt = (P==0) ? 0 : D-P. clk_out and clk_en are computed from the loaded value.
- On every other edge (not RESET, not ALIGN): cnt <= (cnt==D-1) ? 0 : cnt+1; clk_out <= (next_cnt < H); clk_en <= (next_cnt == 0).
- Result: a channel's rising edge lags the P=0 channel by exactly P cycles, and all channels restart in phase after every ALIGN.
- Disabled channel: cnt held 0, clk_out=0, clk_en=0. It rejoins the phase grid at the next ALIGN.
- Counters keep running through SETTLE; extlock gates nothing.
- Reset asserted mid-operation: immediate return to reset values, shadow registers included.

Test Plan:
- Reset release, defaults (NCH=4, DEF_DIV=2, LOCK_CYCLES=16) -> all clk_out toggle every cycle in phase; clk_en every 2nd cycle; extlock rises on edge 18 after release; cfg_ready rises on edge 2.
- Write ch1 div=5 phase=0 while LOCKED -> extlock drops next edge. After ALIGN, clk_out[1] is 3 high / 2 low with clk_en[1] every 5th cycle. extlock returns 17 cycles after ALIGN.
- Write ch2 div=8 phase=3, ch3 div=8 phase=0 -> clk_out[2] rises exactly 3 cycles after clk_out[3], with period 8 on both.
- Edge values: div=0/1 -> behaves as div=2. phase=9 with div=8 -> phase 0. cfg_ch=6 with NCH=4 -> accepted, no extlock drop.
- Same-cycle sync and cfg write -> one ALIGN cycle; cfg_ready low exactly 1 cycle. Write ch0 cfg_en=0 -> clk_out[0] and clk_en[0] stay 0.
- reset_n pulsed low during SETTLE -> outputs 0 asynchronously. After release, div/phase return to defaults and the lock sequence repeats with 18-edge timing.
